msk_demodulator: RTL and testbench
==================================

Name: msk_demodulator

Overview:
- Receive-side counterpart of the TX MSK modulator.
- Consumes the unsigned 8-bit sine-sample stream: 32 samples per bit, 8 bits per frame, LSB first, mid-scale 128.
- Recovers each bit by comparing the sign of the first-half and second-half sample sums; the result is independent of carrier phase.
- Assembles the byte and presents it with a one-cycle valid strobe. Sits between the sample source (ADC/loopback) and the RX byte consumer.

Parameters:
DATA_WIDTH, 8, width of sample_in and data_out
SAMPLES_PER_BIT, 32, samples per symbol; must be even, power of two
BITS_PER_FRAME, 8, bits assembled per data_out word (≤ DATA_WIDTH)

Ports:
G_CLK_TX  input  1  clock
reset  input  1  asynchronous, active-low reset
enable  input  1  when low: state frozen, samples ignored
sync  input  1  marks sample 0 of bit 0; qualified by sample_valid
sample_valid  input  1  sample_in valid this cycle
sample_in  input  DATA_WIDTH  unsigned sample, offset 128
data_out  output  DATA_WIDTH  recovered byte, bit 0 = first received bit
data_valid  output  1  one-cycle pulse, data_out updated
busy  output  1  high while a frame is in progress
phase_err  output  1  valid with data_valid; tied 0 unless PHASE_CHECK_EN

Behaviour:
- Reset: asynchronous, active-low; clock G_CLK_TX. Reset values: data_out=0, data_valid=0, busy=0, phase_err=0; FSM=IDLE; counters, accumulators and shift register cleared.
- Reset asserted mid-frame: frame discarded; no data_valid.
- Accepted sample: enable & sample_valid. Signed value d = sample_in − 128 (DATA_WIDTH+1 bits signed).
- Accumulators: ACC_A sums d over samples 0..SPB/2−1; ACC_B sums d over samples SPB/2..SPB−1. Each is signed, DATA_WIDTH+1+log2(SPB/2) bits (13 at defaults). No saturation is needed.
- FSM states:
  - IDLE: busy=0. An accepted sample with sync=1 counts as sample 0 of bit 0 → RUN. An accepted sample without sync is ignored.
  - RUN: busy=1. sample_cnt counts 0..SPB−1; bit_cnt counts 0..BITS_PER_FRAME−1.
  - On the accepted sample with sample_cnt=SPB−1:
    - bit = (sign(ACC_A) == sign(ACC_B)). Sign uses the final sums including this sample; ≥0 counts as positive.
    - Write bit to shreg[bit_cnt]; clear both accumulators; sample_cnt wraps to 0; bit_cnt increments.
  - When the last bit of the frame completes:
    - Next cycle: data_out ← assembled word, data_valid=1 for exactly one cycle.
    - FSM → IDLE, busy=0 in the same cycle as data_valid.
- Latency: data_valid is 1 cycle after the accepted clock edge of the final sample.
- sync on an accepted sample while in RUN: abort the current frame (no data_valid); that sample becomes sample 0 of bit 0.
- sync while enable=0 or sample_valid=0: ignored.
- Back-to-back frames: a sync in the cycle data_valid is high is accepted normally from IDLE.
- enable=0 mid-frame: all counters and accumulators hold. data_valid pulse is not extended; a pending output register update still completes.
- data_out holds its value until the next completed frame.
- Unused upper data_out bits (when BITS_PER_FRAME < DATA_WIDTH) are 0.

Optional Feature:
- Macro MSK_DEMOD_PHASE_CHECK_EN.
- When defined:
  - Measured phase per bit = (ACC_A < 0) at the half-point (π when negative).
  - Expected phase starts at 0 for bit 0; before bit k>0 it toggles if recovered bit k−1 was 1.
  - Any mismatch within the frame sets a sticky flag. phase_err presents the flag with data_valid; the flag clears on frame start.
- When undefined: no phase logic is generated; phase_err is constant 0.

Decomposition:
- Package msk_pkg:
  - state enum (IDLE, RUN)
  - MIDSCALE = 128
  - default SAMPLES_PER_BIT, BITS_PER_FRAME
  - accumulator width function
  - shared with the modulator for LUT address offsets.
- One natural sub-module, msk_half_accum: sample_cnt plus the ACC_A/ACC_B pair. Outputs bit_done, bit_val, meas_phase.

Test Plan:
- The bench uses a golden modulator model (same 4×32 LUT) for all scenarios.
- Frame 8'hA5 with sync on the first sample, continuous valid → data_valid once, 1 cycle after sample 255; data_out=8'hA5; phase_err=0.
- Frames 8'h00 then 8'hFF back-to-back (sync at sample 0 of each) → data_out=8'h00 then 8'hFF; exactly two data_valid pulses, 256 cycles apart.
- 8'h3C with sample_valid low on every 3rd cycle and enable low for 10 cycles mid-bit 4 → data_out=8'h3C; no spurious pulses.
- 8'h5A with a second sync at sample 100 starting frame 8'hC3 → no output for the aborted frame; data_out=8'hC3.
- reset asserted at sample 150 of 8'h77, then a fresh 8'h11 frame → all outputs 0 during reset; only 8'h11 reported.
- PHASE_CHECK_EN build, 8'h96 with all samples of bit 3 inverted (255 − s) → data_out=8'h96, phase_err=1. Same stimulus without the macro → phase_err=0.

Source files
------------

// File: rtl/msk_pkg.sv
// Shared MSK definitions for the TX modulator and RX demodulator: state encoding,
// mid-scale offset, default symbol geometry and accumulator sizing.
package msk_pkg;
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } msk_state_e;

    localparam int MIDSCALE            = 128;
    localparam int DEF_SAMPLES_PER_BIT = 32;
    localparam int DEF_BITS_PER_FRAME  = 8;

    // Half-symbol sum of (DATA_WIDTH+1)-bit signed samples never overflows this width.
    function automatic int acc_width(input int data_width, input int samples_per_bit);
        return data_width + 1 + $clog2(samples_per_bit / 2);
    endfunction
endpackage

// File: rtl/msk_half_accum.sv
// Sample counter plus first-half / second-half sums of offset-removed samples;
// decides each bit from the signs of the two half sums.
module msk_half_accum
    import msk_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT
) (
    input  logic                  G_CLK_TX,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  sample_acc,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic                  bit_done,
    output logic                  bit_val,
    output logic                  meas_phase
);
    localparam int                  ACC_W    = acc_width(DATA_WIDTH, SAMPLES_PER_BIT);
    localparam int                  CNT_W    = $clog2(SAMPLES_PER_BIT);
    localparam logic [DATA_WIDTH:0] MID      = (DATA_WIDTH + 1)'(MIDSCALE);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);

    logic [DATA_WIDTH:0]     d_raw;
    logic signed [ACC_W-1:0] d_ext;
    logic signed [ACC_W-1:0] sum_b;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_a_q, acc_a_d;
    logic signed [ACC_W-1:0] acc_b_q, acc_b_d;
    logic                    last;

    assign d_raw = {1'b0, sample_in} - MID;
    assign d_ext = ACC_W'($signed(d_raw));
    assign sum_b = acc_b_q + d_ext;
    assign last  = (cnt_q == CNT_LAST);

    // The last sample always lands in the second half, so ACC_A is already final here.
    assign bit_done   = sample_acc & last;
    assign bit_val    = (acc_a_q[ACC_W-1] == sum_b[ACC_W-1]);
    assign meas_phase = acc_a_q[ACC_W-1];

    always_comb begin
        cnt_d   = cnt_q;
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        if (frame_start) begin
            cnt_d   = CNT_W'(1);
            acc_a_d = d_ext;
            acc_b_d = '0;
        end else if (sample_acc) begin
            if (last) begin
                cnt_d   = '0;
                acc_a_d = '0;
                acc_b_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (!cnt_q[CNT_W-1]) begin
                    acc_a_d = acc_a_q + d_ext;
                end else begin
                    acc_b_d = sum_b;
                end
            end
        end
    end

    always_ff @(posedge G_CLK_TX or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
        end
    end
endmodule

// File: rtl/msk_demodulator.sv
// MSK receive demodulator: frames sample stream into bits and bytes with a one-cycle
// data_valid strobe. Optional phase-continuity check under MSK_DEMOD_PHASE_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for an accepted sample with sync; busy=0
// RUN   | frame in progress, counting samples and bits; busy=1
module msk_demodulator
    import msk_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
    parameter int BITS_PER_FRAME  = DEF_BITS_PER_FRAME
) (
    input  logic                  G_CLK_TX,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sync,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  phase_err
);
    localparam int                BIT_W    = (BITS_PER_FRAME > 1) ? $clog2(BITS_PER_FRAME) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(BITS_PER_FRAME - 1);

    msk_state_e                state_q, state_d;
    logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_FRAME-1:0] shreg_q, shreg_d;
    logic [BITS_PER_FRAME-1:0] word;
    logic [DATA_WIDTH-1:0]     word_ext;
    logic [DATA_WIDTH-1:0]     data_out_q, data_out_d;
    logic                      data_valid_q, data_valid_d;

    logic accept;
    logic frame_start;
    logic sample_acc;
    logic bit_done;
    logic bit_val;
    logic meas_phase;
    logic frame_done;

    assign accept      = enable & sample_valid;
    assign frame_start = accept & sync;
    assign sample_acc  = accept & ~sync & (state_q == RUN);
    assign frame_done  = bit_done & (bit_cnt_q == BIT_LAST);

    msk_half_accum #(
        .DATA_WIDTH      (DATA_WIDTH),
        .SAMPLES_PER_BIT (SAMPLES_PER_BIT)
    ) u_half_accum (
        .G_CLK_TX    (G_CLK_TX),
        .reset       (reset),
        .frame_start (frame_start),
        .sample_acc  (sample_acc),
        .sample_in   (sample_in),
        .bit_done    (bit_done),
        .bit_val     (bit_val),
        .meas_phase  (meas_phase)
    );

    always_comb begin
        word           = shreg_q;
        word[bit_cnt_q] = bit_val;
        word_ext       = '0;
        word_ext[BITS_PER_FRAME-1:0] = word;

        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        // A sync sample restarts the frame even mid-frame; the old frame is dropped.
        if (frame_start) begin
            state_d   = RUN;
            bit_cnt_d = '0;
            shreg_d   = '0;
        end else if (bit_done) begin
            if (frame_done) begin
                state_d      = IDLE;
                bit_cnt_d    = '0;
                shreg_d      = '0;
                data_out_d   = word_ext;
                data_valid_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shreg_d   = word;
            end
        end
    end

    always_ff @(posedge G_CLK_TX or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q == RUN);

`ifdef MSK_DEMOD_PHASE_CHECK_EN
    logic exp_phase_q, exp_phase_d;
    logic perr_acc_q, perr_acc_d;
    logic phase_err_q, phase_err_d;
    logic perr_now;

    // Expected carrier phase flips after every 1 bit (half-cycle symbol).
    always_comb begin
        exp_phase_d = exp_phase_q;
        perr_acc_d  = perr_acc_q;
        phase_err_d = phase_err_q;
        perr_now    = perr_acc_q | (meas_phase != exp_phase_q);
        if (frame_start) begin
            exp_phase_d = 1'b0;
            perr_acc_d  = 1'b0;
        end else if (bit_done) begin
            exp_phase_d = exp_phase_q ^ bit_val;
            perr_acc_d  = perr_now;
            if (frame_done) begin
                phase_err_d = perr_now;
            end
        end
    end

    always_ff @(posedge G_CLK_TX or negedge reset) begin
        if (!reset) begin
            exp_phase_q <= 1'b0;
            perr_acc_q  <= 1'b0;
            phase_err_q <= 1'b0;
        end else begin
            exp_phase_q <= exp_phase_d;
            perr_acc_q  <= perr_acc_d;
            phase_err_q <= phase_err_d;
        end
    end

    assign phase_err = phase_err_q;
`else
    logic phase_unused;
    assign phase_unused = meas_phase;
    assign phase_err    = 1'b0;
`endif
endmodule

// File: tb/tb_msk_demodulator.sv
// Bench for msk_demodulator: golden MSK modulator model drives frames; a scoreboard
// monitor checks every data_valid against queued expectations.
module tb_msk_demodulator;
    logic       G_CLK_TX = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       sync = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_in = 8'd128;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       phase_err;

`ifdef MSK_DEMOD_PHASE_CHECK_EN
    localparam bit PHASE_ON = 1'b1;
`else
    localparam bit PHASE_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       perr;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   lut[4][32];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    msk_demodulator dut (
        .G_CLK_TX     (G_CLK_TX),
        .reset        (reset),
        .enable       (enable),
        .sync         (sync),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .busy         (busy),
        .phase_err    (phase_err)
    );

    always #5 G_CLK_TX = ~G_CLK_TX;
    always @(posedge G_CLK_TX) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor
    always @(negedge G_CLK_TX) begin
        if (reset && data_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got pulse with data_out 0x%0h at cycle %0d expected no pulse",
                         data_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data_out", 32'(data_out), 32'(e.data));
                check("phase_err", 32'(phase_err), 32'(e.perr));
                check("valid_cycle", 32'(cyc), 32'(e.cyc));
                check("busy_at_valid", 32'(busy), 32'd0);
            end
        end
    end

    task automatic drive(input logic [7:0] s, input logic sy, input logic v, input logic en);
        sample_in = s; sync = sy; sample_valid = v; enable = en;
        @(posedge G_CLK_TX); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(8'($urandom), 1'b0, 1'b0, 1'b1);
    endtask

    // Modulator model: bit 1 = half sine cycle (flips carrier phase), bit 0 = full cycle.
    // gap_mode 0: continuous, 1: valid low every 3rd cycle, 2: random valid/enable gaps.
    task automatic send_frame(input logic [7:0] b, input int gap_mode, input int pause_bit,
                              input int inv_bit, input int stop_at);
        int   phase;
        int   g;
        int   bk;
        int   idx;
        int   s;
        exp_t e;
        phase = 0;
        g = 0;
        for (int n = 0; n < 256; n++) begin
            if (n == stop_at) return;
            bk = n / 32;
            idx = n % 32;
            if (gap_mode == 1) begin
                g++;
                if (g % 3 == 0) begin
                    drive(8'($urandom), 1'b1, 1'b0, 1'b1);
                    g++;
                end
            end else if (gap_mode == 2) begin
                for (int k = 0; k < 3 && $urandom_range(0, 3) == 0; k++) begin
                    if ($urandom_range(0, 1) == 1) drive(8'($urandom), 1'($urandom), 1'b0, 1'b1);
                    else drive(8'($urandom), 1'($urandom), 1'b1, 1'b0);
                end
            end
            if (bk == pause_bit && idx == 10)
                for (int k = 0; k < 10; k++) drive(8'($urandom), 1'b1, 1'b1, 1'b0);
            s = lut[(b[bk] ? 2 : 0) + phase][idx];
            if (bk == inv_bit) s = 255 - s;
            if (n == 255) begin
                e.data = b;
                e.perr = PHASE_ON && (inv_bit >= 0);
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
            drive(8'(s), (n == 0), 1'b1, 1'b1);
            if (n == 0) check("busy_after_sync", 32'(busy), 32'd1);
            if (idx == 31 && b[bk]) phase ^= 1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 ns expected bench end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int         inv;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) begin
                real v;
                v = $sin(((r >= 2) ? 1.0 : 2.0) * 3.14159265358979 * i / 32.0);
                if (r % 2 == 1) v = -v;
                lut[r][i] = 128 + int'(100.0 * v);
            end
        end

        repeat (3) @(posedge G_CLK_TX);
        #1;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_phase_err", 32'(phase_err), 32'd0);
        reset = 1'b1;
        idle(3);

        send_frame(8'hA5, 0, -1, -1, -1);
        idle(5);
        check("data_out_hold", 32'(data_out), 32'hA5);

        send_frame(8'h00, 0, -1, -1, -1);
        send_frame(8'hFF, 0, -1, -1, -1);
        idle(3);

        send_frame(8'h3C, 1, 4, -1, -1);
        idle(3);

        send_frame(8'h5A, 0, -1, -1, 100);
        send_frame(8'hC3, 0, -1, -1, -1);
        idle(3);

        // Accepted samples without sync in IDLE must be ignored.
        for (int k = 0; k < 40; k++) drive(8'($urandom), 1'b0, 1'b1, 1'b1);
        check("idle_ignores_busy", 32'(busy), 32'd0);
        check("idle_ignores_data", 32'(data_out), 32'hC3);

        send_frame(8'h77, 0, -1, -1, 150);
        reset = 1'b0;
        #2;
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_data_valid", 32'(data_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_phase_err", 32'(phase_err), 32'd0);
        repeat (3) @(posedge G_CLK_TX);
        #1;
        reset = 1'b1;
        idle(2);
        send_frame(8'h11, 0, -1, -1, -1);
        idle(3);

        send_frame(8'h96, 0, -1, 3, -1);
        idle(3);

        for (int f = 0; f < 8; f++) begin
            rb = 8'($urandom);
            inv = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            send_frame(rb, 2, -1, inv, -1);
            idle(int'($urandom_range(0, 4)));
        end

        idle(5);
        check("all_frames_reported", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
